// File: rtl/serial2parallel_hs_if.sv
// Handshake bundle for serial2parallel_hs: serial input side and word output side.
// PARITY_CHK_EN adds the dout_perr signal.
interface serial2parallel_hs_if #(
  parameter int DATA_W = 8
);
  logic              din_serial;
  logic              din_valid;
  logic              msb_first;
  logic              sync_clr;
  logic [DATA_W-1:0] dout_parallel;
  logic              dout_valid;
  logic              dout_ready;
  logic              overflow;
`ifdef PARITY_CHK_EN
  logic              dout_perr;
`endif

  modport master (
    output din_serial, din_valid, msb_first, sync_clr, dout_ready,
    input  dout_parallel, dout_valid, overflow
`ifdef PARITY_CHK_EN
    , input dout_perr
`endif
  );

  modport slave (
    input  din_serial, din_valid, msb_first, sync_clr, dout_ready,
    output dout_parallel, dout_valid, overflow
`ifdef PARITY_CHK_EN
    , output dout_perr
`endif
  );
endinterface

// File: rtl/serial2parallel_hs.sv
// Serial-to-parallel deserialiser with selectable bit order and valid/ready output.
// Optional feature macro PARITY_CHK_EN: trailing even-parity bit per word, checked into dout_perr.
module serial2parallel_hs #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial2parallel_hs_if.slave bus
);

`ifdef PARITY_CHK_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_dout;
  logic              r_msb;
  logic              r_valid;
  logic              r_ovf;

  logic              w_order;
  logic              w_last;
  logic              w_done;
  logic              w_accept;
  logic              w_load;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_word;

`ifdef PARITY_CHK_EN
  logic              r_par;
  logic              r_perr;
  logic              w_perr;
`endif

  always_comb begin
    // bit order is taken live on the first bit, then from the latched copy
    w_order     = (r_cnt == '0) ? bus.msb_first : r_msb;
    w_shift_nxt = w_order ? {r_shift[DATA_W-2:0], bus.din_serial}
                          : {bus.din_serial, r_shift[DATA_W-1:1]};
    w_last      = (r_cnt == CNT_W'(FRAME_W - 1));
    w_done      = bus.din_valid && w_last;
    w_accept    = r_valid && bus.dout_ready;
    w_load      = w_done && (!r_valid || bus.dout_ready);
`ifdef PARITY_CHK_EN
    // data is already complete when the parity bit arrives
    w_word      = r_shift;
    w_perr      = r_par ^ bus.din_serial;
`else
    w_word      = w_shift_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_msb   <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef PARITY_CHK_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else if (bus.sync_clr) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef PARITY_CHK_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      if (bus.din_valid) begin
        if (r_cnt == '0) r_msb <= bus.msb_first;
        if (w_last) begin
          r_cnt   <= '0;
          r_shift <= '0;
`ifdef PARITY_CHK_EN
          r_par   <= 1'b0;
`endif
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          r_shift <= w_shift_nxt;
`ifdef PARITY_CHK_EN
          r_par   <= r_par ^ bus.din_serial;
`endif
        end
      end

      // a word completing on the accept edge replaces the accepted one
      if (w_load) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
`ifdef PARITY_CHK_EN
        r_perr  <= w_perr;
`endif
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_done && !w_load) r_ovf <= 1'b1;
    end
  end

  assign bus.dout_parallel = r_dout;
  assign bus.dout_valid    = r_valid;
  assign bus.overflow      = r_ovf;
`ifdef PARITY_CHK_EN
  assign bus.dout_perr     = r_perr;
`endif

endmodule
